// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: owns the coefficient bank and sample delay line,
// and runs one shared signed MAC over all taps for each accepted sample.
module fir_mac_sequencer #(
    parameter int NTAPS = 16,
    parameter int DW    = 16,
    parameter int ACCW  = 40
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic                     coef_wr,
    input  logic [$clog2(NTAPS)-1:0] coef_idx,
    input  logic signed [DW-1:0]     coef_data,
    input  logic                     clear,
    input  logic                     smp_valid,
    output logic                     smp_ready,
    input  logic signed [DW-1:0]     smp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACCW-1:0]   out_data,
    output logic                     busy,
    output logic                     coef_err
);

    localparam int TAPW = $clog2(NTAPS);
    localparam logic [TAPW-1:0] LAST_TAP = TAPW'(NTAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [DW-1:0]   r_coef [NTAPS];
    logic signed [DW-1:0]   r_x    [NTAPS];
    logic signed [ACCW-1:0] r_acc;
    logic [TAPW-1:0]        r_tap;
    logic                   r_out_valid;
    logic signed [ACCW-1:0] r_out_data;
    logic                   r_coef_err;

    logic                   w_smp_ready;
    logic                   w_accept;
    logic                   w_last_tap;
    logic                   w_coef_we;
    logic                   w_coef_rej;
    logic                   w_busy;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_sum;

    // Full-precision product, sign-extended; the sum wraps modulo 2^ACCW.
    assign w_prod     = r_coef[r_tap] * r_x[r_tap];
    assign w_prod_ext = {{(ACCW - 2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every comb output is given a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
                S_MAC:   if (w_last_tap) w_state_nxt = S_OUT;
                S_OUT:   if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_smp_ready = S_AXI_ARESETN && (r_state == S_IDLE) && !clear;
        w_accept    = w_smp_ready && smp_valid;
        w_last_tap  = (r_state == S_MAC) && (r_tap == LAST_TAP);
        // A write racing a clear always lands, even mid-MAC.
        w_coef_we   = coef_wr && ((r_state != S_MAC) || clear);
        w_coef_rej  = coef_wr && (r_state == S_MAC) && !clear;
        w_busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            // NOTE: the coefficient bank and delay line are architecturally
            // visible after reset, so they are reset explicitly here.
            for (int k = 0; k < NTAPS; k++) begin
                r_coef[k] <= '0;
                r_x[k]    <= '0;
            end
            r_acc       <= '0;
            r_tap       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_coef_err  <= 1'b0;
        end else begin
            if (w_coef_we) begin
                r_coef[coef_idx] <= coef_data;
            end
            if (clear) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_x[k] <= '0;
                end
                r_acc       <= '0;
                r_tap       <= '0;
                r_out_valid <= 1'b0;
                r_coef_err  <= 1'b0;
            end else begin
                if (w_coef_rej) begin
                    r_coef_err <= 1'b1;
                end
                if (w_accept) begin
                    for (int k = 1; k < NTAPS; k++) begin
                        r_x[k] <= r_x[k-1];
                    end
                    r_x[0] <= smp_data;
                    r_acc  <= '0;
                    r_tap  <= '0;
                end else if (r_state == S_MAC) begin
                    r_acc <= w_sum;
                    r_tap <= r_tap + 1'b1;
                    if (w_last_tap) begin
                        r_out_data  <= w_sum;
                        r_out_valid <= 1'b1;
                    end
                end else if ((r_state == S_OUT) && r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign smp_ready = w_smp_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign coef_err  = r_coef_err;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (NTAPS=16, DW=16, ACCW=40) with
// hand-computed expected results checked by immediate assertions.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 16;
    localparam int DW    = 16;
    localparam int ACCW  = 40;
    localparam logic [ACCW-1:0] NEG_MAX = 40'hFF_FFFF_8000;

    logic                 S_AXI_ACLK;
    logic                 S_AXI_ARESETN;
    logic                 coef_wr;
    logic [3:0]           coef_idx;
    logic signed [DW-1:0] coef_data;
    logic                 clear;
    logic                 smp_valid;
    logic                 smp_ready;
    logic signed [DW-1:0] smp_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACCW-1:0]      out_data;
    logic                 busy;
    logic                 coef_err;

    int checks = 0;
    int errors = 0;

    fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW)) dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .coef_wr      (coef_wr),
        .coef_idx     (coef_idx),
        .coef_data    (coef_data),
        .clear        (clear),
        .smp_valid    (smp_valid),
        .smp_ready    (smp_ready),
        .smp_data     (smp_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .coef_err     (coef_err)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input int idx, input logic [DW-1:0] val);
        coef_wr   = 1'b1;
        coef_idx  = 4'(idx);
        coef_data = val;
        tick();
        coef_wr   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Feed one sample and consume its result. wr_cycle>0 injects a coefficient
    // write in that MAC cycle; wr_cycle==0 writes during the handshake cycle.
    task automatic send_sample(input string tag, input logic [DW-1:0] d,
                               input logic [ACCW-1:0] exp, input int hold,
                               input int wr_cycle, input int wr_idx,
                               input logic [DW-1:0] wr_data);
        int n;
        logic [ACCW-1:0] held;
        n = 0;
        while (!smp_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(smp_ready), 64'd1);
        smp_valid = 1'b1;
        smp_data  = d;
        if (wr_cycle == 0) begin
            coef_wr   = 1'b1;
            coef_idx  = 4'(wr_idx);
            coef_data = wr_data;
        end
        tick();
        smp_valid = 1'b0;
        coef_wr   = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            if (n == 1) begin
                check({tag, "_busy_mac"}, {63'd0, busy, smp_ready}, 64'd2);
            end
            if (n == wr_cycle) begin
                coef_wr   = 1'b1;
                coef_idx  = 4'(wr_idx);
                coef_data = wr_data;
            end
            tick();
            coef_wr = 1'b0;
            if (wr_cycle > 0 && n == wr_cycle) begin
                check({tag, "_coef_err_set"}, 64'(coef_err), 64'd1);
            end
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(NTAPS + 1));
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        held = out_data;
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                if (out_data !== held) begin
                    held = out_data;
                end
            end
            check({tag, "_bp_data"}, 64'(held), 64'(exp));
            check({tag, "_bp_flags"}, {60'd0, out_valid, smp_ready, busy, 1'b0}, 64'hA);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {61'd0, smp_ready, busy, out_valid}, 64'h4);
    endtask

    initial begin : stim
        int saw;
        S_AXI_ARESETN = 1'b0;
        coef_wr   = 1'b0;
        coef_idx  = '0;
        coef_data = '0;
        clear     = 1'b0;
        smp_valid = 1'b0;
        smp_data  = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready_low", 64'(smp_ready), 64'd0);
        check("rst_outputs", {60'd0, out_valid, busy, coef_err, 1'b0}, 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        S_AXI_ARESETN = 1'b1;
        #1;
        check("rst_release_ready", 64'(smp_ready), 64'd1);

        // Impulse response: coef[k]=k+1, feed 1 then fifteen 0s
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'(k + 1));
        for (int s = 0; s < NTAPS; s++) begin
            send_sample($sformatf("imp%0d", s), (s == 0) ? 16'd1 : 16'd0,
                        40'(s + 1), 0, -1, 0, 16'd0);
        end

        // Extreme values: n-th output is n*2^30, no wrap at n=16
        do_clear();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h8000);
        for (int s = 1; s <= NTAPS; s++) begin
            send_sample($sformatf("ext%0d", s), 16'h8000, 40'(s) << 30, 0, -1, 0, 16'd0);
        end
        check("ext_coef_err", 64'(coef_err), 64'd0);

        // Rejected coefficient write to idx 3 during MAC
        do_clear();
        send_sample("rej_a", 16'd1, NEG_MAX, 0, -1, 0, 16'd0);
        send_sample("rej_b", 16'd0, NEG_MAX, 0, -1, 0, 16'd0);
        send_sample("rej_c", 16'd0, NEG_MAX, 0, 2, 3, 16'd5);
        check("rej_sticky", 64'(coef_err), 64'd1);
        send_sample("rej_d", 16'd0, NEG_MAX, 0, -1, 0, 16'd0);
        do_clear();
        check("rej_cleared", 64'(coef_err), 64'd0);

        // Clear mid-MAC aborts the computation; clear beats smp_valid
        write_coef(0, 16'd2);
        smp_valid = 1'b1;
        smp_data  = 16'sd99;
        tick();
        smp_valid = 1'b0;
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", {62'd0, busy, out_valid}, 64'd0);
        saw = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid) saw++;
        end
        check("clr_no_output", 64'(saw), 64'd0);
        clear     = 1'b1;
        smp_valid = 1'b1;
        smp_data  = 16'sd50;
        #1;
        check("clr_vs_valid_ready", 64'(smp_ready), 64'd0);
        tick();
        clear     = 1'b0;
        smp_valid = 1'b0;
        check("clr_vs_valid_idle", 64'(busy), 64'd0);
        // Backpressure for 10 cycles on this result
        send_sample("clr_next", 16'sd7, 40'd14, 10, -1, 0, 16'd0);

        // Reset during OUT
        smp_valid = 1'b1;
        smp_data  = 16'sd3;
        tick();
        smp_valid = 1'b0;
        saw = 0;
        while (!out_valid && saw < 40) begin
            tick();
            saw++;
        end
        check("rout_reached_out", 64'(out_valid), 64'd1);
        S_AXI_ARESETN = 1'b0;
        tick();
        check("rout_flags", {61'd0, out_valid, busy, smp_ready}, 64'd0);
        check("rout_data", 64'(out_data), 64'd0);
        tick();
        S_AXI_ARESETN = 1'b1;
        #1;
        check("rout_release_ready", 64'(smp_ready), 64'd1);
        send_sample("rout_zero", 16'sd5, 40'd0, 0, -1, 0, 16'd0);
        // Write in the handshake cycle is used by this computation
        send_sample("hs_write", 16'sd4, 40'd12, 0, 0, 0, 16'd3);
        check("hs_write_no_err", 64'(coef_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR engine controller for the adaptive FIR. It owns the coefficient bank and the sample delay line, and sequences a single shared signed multiply-accumulate over all taps for each accepted input sample. It sits between the AXI4-Lite register file, which supplies coefficient writes, samples and control pulses, and the result/status registers read back over AXI.

## Interface
Parameters:
- NTAPS, 16: number of taps; must be a power of 2, ≥2.
- DW, 16: signed width of samples and coefficients.
- ACCW, 40: signed accumulator and result width; must be ≥ 2*DW + $clog2(NTAPS).

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic on the rising edge.
- S_AXI_ARESETN  in  1  reset; synchronous, active-low.
- coef_wr  in  1  one-cycle coefficient write strobe.
- coef_idx  in  $clog2(NTAPS)  coefficient index k.
- coef_data  in  DW  signed coefficient value.
- clear  in  1  one-cycle strobe: flush delay line and abort the current computation.
- smp_valid  in  1  input sample valid.
- smp_ready  out  1  engine can accept a sample.
- smp_data  in  DW  signed input sample.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACCW  signed result y.
- busy  out  1  high in MAC or OUT state.
- coef_err  out  1  sticky flag: a coefficient write was rejected.

## Operation
- Function: y = Σ_{k=0..NTAPS-1} coef[k]·x[k]. x[0] is the newest sample and x[NTAPS-1] is the oldest.
- FSM states: IDLE, MAC, OUT.
  - IDLE: smp_ready=1 unless clear=1. On smp_valid&&smp_ready:
    - delay line shifts (x[k]<=x[k-1], x[0]<=smp_data);
    - acc<=0, tap<=0;
    - state goes to MAC.
  - MAC: each cycle acc<=acc+sext(coef[tap]·x[tap]) and tap<=tap+1. The final cycle is when tap=NTAPS-1: out_data<=final sum, out_valid<=1, state goes to OUT.
  - OUT: out_data holds stable. On out_valid&&out_ready: out_valid<=0, state goes to IDLE.
- Coefficient write:
  - When coef_wr=1 in IDLE or OUT: coef[coef_idx]<=coef_data at that edge.
  - When coef_wr=1 in MAC: the write is discarded, coef_err<=1, and the computation is unaffected.
- clear, in any state:
  - all x[k]<=0, acc<=0, out_valid<=0, coef_err<=0, state goes to IDLE;
  - coefficients are preserved.
- Simultaneous events:
  - clear with smp_valid in IDLE: clear wins and no sample is accepted (smp_ready is low).
  - clear with coef_wr: the write is always performed and coef_err ends at 0.
  - coef_wr in the same IDLE cycle as a sample acceptance: the write lands before the first MAC cycle and is used.
- Arithmetic:
  - full 2*DW-bit signed product, sign-extended to ACCW;
  - accumulation wraps modulo 2^ACCW (no saturation);
  - with ACCW at or above the minimum, no overflow is possible.
- busy = (state != IDLE).

## Timing
- Reset (S_AXI_ARESETN low at an edge):
  - state IDLE; all coefficients and delay-line entries 0; acc 0; tap 0;
  - out_valid 0, out_data 0, coef_err 0, busy 0;
  - smp_ready is forced 0 while S_AXI_ARESETN is low and is 1 in the first cycle after release.
- Reset asserted mid-MAC or mid-OUT aborts the computation with no output.
- Latency: counting the sample handshake cycle as cycle 0, MAC occupies cycles 1..NTAPS and out_valid is first high in cycle NTAPS+1.
- Throughput: with out_ready held high, one sample every NTAPS+2 cycles. The sequence is handshake, NTAPS MAC cycles, OUT cycle, then the next sample is accepted in IDLE.
- Backpressure: out_valid stays high and out_data stays stable until out_ready; smp_ready stays 0 throughout.
- coef_err is set on the edge after the rejected write, and clears only on clear or reset.
- Only one computation is ever in flight; the tap counter never wraps within a computation.

## Test plan
- Impulse response (NTAPS=16):
  - Stimulus: coef[k]=k+1; feed 1, then fifteen 0s.
  - Required: outputs 1,2,…,16, each with out_valid first high 17 cycles after its handshake.
- Extreme values:
  - Stimulus: all coef=-32768, all samples -32768, 16 samples fed.
  - Required: 16th output = 16·2^30 = 0x04_0000_0000 with no wrap; earlier outputs n·2^30.
- Rejected coefficient write:
  - Stimulus: coef_wr to idx 3 during a MAC cycle.
  - Required: coef_err=1 next cycle, result unchanged, coef[3] unchanged on the next sample; clear then drops coef_err.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Required: out_data stable, smp_ready=0, busy=1; out_ready=1 gives IDLE and smp_ready=1 next cycle.
- Clear mid-MAC:
  - Stimulus: clear at MAC cycle 5, then sample 7 with coef[0]=2.
  - Required: no output for the aborted sample, out_valid=0; next result = 14 since the delay line is zeroed.
- Reset mid-OUT:
  - Stimulus: assert S_AXI_ARESETN=0 while out_valid=1.
  - Required: out_valid=0, out_data=0, coefficients 0; after release a sample yields y=0.
